uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Serial receiver for the UART link: consumes the frame that the transmit FSM and datapath put on the line (start, 8 data bits LSB first, parity, stop) and returns the parallel byte plus error status. It uses a 16× oversampling tick from the baud generator. It synchronises the asynchronous line, detects the start edge, samples each bit at mid-bit, checks parity and stop, and presents the byte with a one-cycle valid strobe to the host side.

## Interface
Parameters:
- DATA_W, 8, data bits per frame
- PARITY_ODD, 0, 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- rx_in  input  1  serial line, idle high, asynchronous to clk
- tick16  input  1  one-clk pulse at 16× baud rate from baud generator
- rx_data  output  DATA_W  last received byte
- rx_valid  output  1  one-clk strobe, frame complete
- parity_err  output  1  parity mismatch on last frame
- frame_err  output  1  stop bit sampled low on last frame
- rx_busy  output  1  high while state != IDLE

## Operation
- Line conditioning:
  - rx_in passes through a 2-flop synchroniser, reset to 1.
  - A third flop holds the previous synced value.
  - A falling edge is synced 0 with previous synced value 1.
- States use the same encoding as the transmit FSM: IDLE=3'b000, START_BIT=3'b001, DATA_BIT=3'b010, PARITY_BIT=3'b011, STOP_BIT=3'b100. All other codes go to IDLE.
- tick_cnt is 4 bits. bit_cnt is 3 bits. Both are cleared on every state change.
- IDLE: on a falling edge, go to START_BIT with tick_cnt=0. No tick16 is needed for the transition.
- START_BIT: tick_cnt increments on each tick16. On tick16 with tick_cnt==7 (mid-bit), sample the line:
  - 0: go to DATA_BIT.
  - 1: false start; go to IDLE with no strobe and no flag change.
- DATA_BIT: on tick16 with tick_cnt==15, sample the line into shift register bit bit_cnt (LSB first) and increment bit_cnt. After the sample taken at bit_cnt==7, go to PARITY_BIT.
- PARITY_BIT: on tick16 with tick_cnt==15, sample the parity bit and compute the parity error.
- STOP_BIT: on tick16 with tick_cnt==15, sample the stop bit, then go to IDLE. On the next clk:
  - rx_data is loaded.
  - rx_valid pulses.
  - parity_err and frame_err are loaded (frame_err = stop bit was 0).
- Frames with errors are still delivered. The flags hold until the next completed frame.
- Break or stuck-low line: after STOP_BIT returns to IDLE, no new start is accepted until the line has been seen high, because edge detection requires 1 then 0.
- tick16 pulses arriving in IDLE are ignored.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, synchroniser flops=1.
- Reset asserted mid-frame aborts immediately. The partial byte is discarded and no strobe is produced.
- Synchroniser latency: 2 clk from rx_in to synced value. The edge is recognised on the 3rd clk.
- Sample points:
  - Start bit: 8th tick16 after edge detection.
  - Each later bit: 16 tick16 after the previous sample.
- rx_valid rises exactly 1 clk after the tick16 that samples the stop bit, for exactly 1 clk. It has no back-pressure: the host must capture on the strobe.
- rx_busy is decoded from the state register. It rises 1 clk after edge detection and falls when STOP_BIT exits.
- Back-to-back frames: a start edge immediately after the mid-stop sample must be accepted with no lost frame.
- Simultaneous tick16 and state exit: the sample is taken on that tick. Counters restart from 0 in the new state.

## Structure
- Shared package uart_pkg holds:
  - State encoding constants (IDLE..STOP_BIT), shared with the transmit FSM.
  - OVERSAMPLE=16, MID_TICK=7, LAST_TICK=15.
  - Default DATA_W.
- One sub-module, uart_rx_sync: 2-flop synchroniser plus previous-value flop. Outputs rx_s and fall_edge; reset values 1.
- The FSM, counters, shift register and parity check stay in uart_rx_fsm.

## Test plan
- Nominal byte: frame 0xA5, parity 0, stop 1, 16 tick16 per bit, tick16 every 4 clk. Required: rx_data=0xA5 and rx_valid for 1 clk, parity_err=0, frame_err=0, rx_busy low afterward.
- Parity error: 0x3C sent with parity bit 1 (even mode). Required: rx_data=0x3C, rx_valid=1, parity_err=1, frame_err=0. A following good frame 0x00 clears parity_err.
- Framing error: 0x81 with stop bit 0, line held low for 2 bit times, then high. Required: rx_valid with frame_err=1 and exactly one strobe. The next frame 0x7E is received cleanly.
- Glitch rejection: rx_in low for 4 tick16, then high. Required: return to IDLE, no rx_valid, rx_data and flags unchanged.
- Reset mid-frame: assert rstn low during the 4th data bit of 0xF0. Required: all outputs are at reset values while rstn is low. After release, frame 0x5A gives rx_data=0x5A with no spurious strobe.
- Back-to-back: frames 0x01 then 0xFF with no idle gap, PARITY_ODD=1 build. Required: two strobes, data 0x01 then 0xFF, no error flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to the transmit and receive FSMs,
// oversampling constants and the default frame width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    START_BIT  = 3'b001,
    DATA_BIT   = 3'b010,
    PARITY_BIT = 3'b011,
    STOP_BIT   = 3'b100
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a history flop
// used to detect the high-to-low start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_edge
);

  // [0],[1] synchronise; [2] is the previous synced value. All reset to idle-high.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 3'b111;
    end else begin
      // NOTE: non-blocking so every flop takes its neighbour's pre-edge value (a true shift).
      sync_q <= {sync_q[1:0], rx_in};
    end
  end

  assign rx_s      = sync_q[1];
  assign fall_edge = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 16x oversampled start/data/parity/stop FSM delivering a byte
// with a one-cycle valid strobe and parity/framing status.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_in,
  input  logic              tick16,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic rx_s;
  logic fall_edge;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .rx_in    (rx_in),
    .rx_s     (rx_s),
    .fall_edge(fall_edge)
  );

  uart_state_e       state_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it is reset like the rest.
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_edge) begin
            state_q    <= START_BIT;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end
        START_BIT: begin
          if (tick16) begin
            if (tick_cnt_q == MID_TICK) begin
              // A high line at mid-start is a glitch: drop it silently.
              state_q    <= rx_s ? IDLE : DATA_BIT;
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        DATA_BIT: begin
          if (tick16) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_cnt_q == LAST_TICK) begin
              shift_q[bit_cnt_q] <= rx_s;
              bit_cnt_q          <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_BIT) begin
                state_q    <= PARITY_BIT;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end
            end
          end
        end
        PARITY_BIT: begin
          if (tick16) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_cnt_q == LAST_TICK) begin
              par_err_q  <= rx_s ^ (^shift_q) ^ PARITY_ODD;
              state_q    <= STOP_BIT;
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
            end
          end
        end
        STOP_BIT: begin
          if (tick16) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_cnt_q == LAST_TICK) begin
              state_q    <= IDLE;
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              rx_data    <= shift_q;
              rx_valid   <= 1'b1;
              parity_err <= par_err_q;
              frame_err  <= ~rx_s;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: an even-parity and an odd-parity instance,
// directed frames pushed as expectations, per-instance monitors popping on rx_valid.
module tb_uart_rx_fsm;
  import uart_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = OVERSAMPLE * TICK_DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk;
  logic rstn;
  logic tick16;
  logic rx_e, rx_o;

  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o;
  logic       perr_e, perr_o;
  logic       ferr_e, ferr_o;
  logic       busy_e, busy_o;

  exp_t exp_e[$];
  exp_t exp_o[$];

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fsm #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rstn(rstn), .rx_in(rx_e), .tick16(tick16),
    .rx_data(data_e), .rx_valid(valid_e), .parity_err(perr_e),
    .frame_err(ferr_e), .rx_busy(busy_e)
  );

  uart_rx_fsm #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rstn(rstn), .rx_in(rx_o), .tick16(tick16),
    .rx_data(data_o), .rx_valid(valid_o), .parity_err(perr_o),
    .frame_err(ferr_o), .rx_busy(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick16 = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      tick16 = 1'b1;
      @(negedge clk);
      tick16 = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: sample on the falling edge, pop on every strobe, and require the strobe to last one clk.
  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) check("even_strobe_width", 32'(valid_e), 32'd0);
      if (valid_e && !prev) begin
        if (exp_e.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL even_unexpected_strobe: got data %0h expected no strobe", data_e);
        end else begin
          e = exp_e.pop_front();
          check("even_data", 32'(data_e), 32'(e.data));
          check("even_parity_err", 32'(perr_e), 32'(e.perr));
          check("even_frame_err", 32'(ferr_e), 32'(e.ferr));
        end
      end
      prev = valid_e;
    end
  end

  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) check("odd_strobe_width", 32'(valid_o), 32'd0);
      if (valid_o && !prev) begin
        if (exp_o.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL odd_unexpected_strobe: got data %0h expected no strobe", data_o);
        end else begin
          e = exp_o.pop_front();
          check("odd_data", 32'(data_o), 32'(e.data));
          check("odd_parity_err", 32'(perr_o), 32'(e.perr));
          check("odd_frame_err", 32'(ferr_o), 32'(e.ferr));
        end
      end
      prev = valid_o;
    end
  end

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_e = v;
    else          rx_o = v;
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic par,
                            input logic stop, input int stop_bits);
    set_line(sel, 1'b0);
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      hold_bits(1);
    end
    set_line(sel, par);
    hold_bits(1);
    set_line(sel, stop);
    hold_bits(stop_bits);
    set_line(sel, 1'b1);
  endtask

  task automatic push_even(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    exp_e.push_back(e);
  endtask

  task automatic push_odd(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    exp_o.push_back(e);
  endtask

  initial begin
    rstn = 1'b0;
    rx_e = 1'b1;
    rx_o = 1'b1;
    repeat (4) @(negedge clk);

    check("reset_data", 32'(data_e), 32'h0);
    check("reset_valid", 32'(valid_e), 32'h0);
    check("reset_parity_err", 32'(perr_e), 32'h0);
    check("reset_frame_err", 32'(ferr_e), 32'h0);
    check("reset_busy", 32'(busy_e), 32'h0);

    rstn = 1'b1;
    hold_bits(1);

    // Nominal 0xA5: four ones, even parity bit 0.
    push_even(8'hA5, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1);
    hold_bits(1);
    check("busy_after_a5", 32'(busy_e), 32'h0);

    // 0x3C has even parity 0; sending 1 must flag, then 0x00 with correct parity clears it.
    push_even(8'h3C, 1'b1, 1'b0);
    send_frame(0, 8'h3C, 1'b1, 1'b1, 1);
    hold_bits(1);
    check("perr_held_after_3c", 32'(perr_e), 32'h1);
    push_even(8'h00, 1'b0, 1'b0);
    send_frame(0, 8'h00, 1'b0, 1'b1, 1);
    hold_bits(1);
    check("perr_cleared_by_00", 32'(perr_e), 32'h0);

    // 0x81 with stop low, line low for two bit times, then idle; then a clean 0x7E.
    push_even(8'h81, 1'b0, 1'b1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 2);
    hold_bits(2);
    check("ferr_held_after_81", 32'(ferr_e), 32'h1);
    push_even(8'h7E, 1'b0, 1'b0);
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1);
    hold_bits(1);
    check("ferr_cleared_by_7e", 32'(ferr_e), 32'h0);

    // Glitch: low for 4 ticks only; the receiver goes busy, then abandons at mid-start.
    set_line(0, 1'b0);
    repeat (8) @(negedge clk);
    check("glitch_busy_high", 32'(busy_e), 32'h1);
    repeat (4 * TICK_DIV - 8) @(negedge clk);
    set_line(0, 1'b1);
    hold_bits(2);
    check("glitch_busy_low", 32'(busy_e), 32'h0);
    check("glitch_data_kept", 32'(data_e), 32'h7E);
    check("glitch_perr_kept", 32'(perr_e), 32'h0);
    check("glitch_ferr_kept", 32'(ferr_e), 32'h0);

    // Reset during data bit 3 of 0xF0 (start, bits 0..2, half of bit 3 all low).
    set_line(0, 1'b0);
    hold_bits(4);
    repeat (BIT_CLK / 2) @(negedge clk);
    check("busy_mid_f0", 32'(busy_e), 32'h1);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_data", 32'(data_e), 32'h0);
    check("midrst_valid", 32'(valid_e), 32'h0);
    check("midrst_parity_err", 32'(perr_e), 32'h0);
    check("midrst_frame_err", 32'(ferr_e), 32'h0);
    check("midrst_busy", 32'(busy_e), 32'h0);
    set_line(0, 1'b1);
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    hold_bits(1);
    push_even(8'h5A, 1'b0, 1'b0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1);
    hold_bits(1);

    // Odd build, back-to-back: 0x01 odd parity bit 0, 0xFF odd parity bit 1.
    push_odd(8'h01, 1'b0, 1'b0);
    push_odd(8'hFF, 1'b0, 1'b0);
    send_frame(1, 8'h01, 1'b0, 1'b1, 1);
    send_frame(1, 8'hFF, 1'b1, 1'b1, 1);
    hold_bits(2);
    check("odd_busy_low", 32'(busy_o), 32'h0);

    check("even_queue_drained", 32'(exp_e.size()), 32'd0);
    check("odd_queue_drained", 32'(exp_o.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
